lmmi_dphy_arb: RTL

LMMI_DPHY_ARB -- requirements
Module: lmmi_dphy_arb

---
 rtl/lmmi_dphy_arb_pkg.sv | 20 ++
 rtl/lmmi_timeout_cnt.sv | 29 ++
 rtl/lmmi_dphy_arb.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lmmi_dphy_arb_pkg.sv
// Shared types and widths for the two-requester LMMI arbiter in front of the DPHY port.
package lmmi_dphy_arb_pkg;

  localparam int OFFSET_W = 5;
  localparam int DATA_W   = 4;
  localparam int NUM_REQ  = 2;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  // Per-requester strobe for a one-bit owner index.
  function automatic logic [NUM_REQ-1:0] owner_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lmmi_timeout_cnt.sv
// Read-data timeout counter: cleared outside the wait, counts while enabled, flags the terminal value.
module lmmi_timeout_cnt
  import lmmi_dphy_arb_pkg::*;
#(
  parameter int unsigned TERMINAL = 63
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc = (r_cnt == CNT_W'(TERMINAL));

  // Holds at the terminal value so a late enable never wraps back to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lmmi_dphy_arb.sv
// Two-requester arbiter for the DPHY LMMI port: one transaction in flight, alternating tie priority.
module lmmi_dphy_arb
  import lmmi_dphy_arb_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic                         LMMICLK,
  input  logic                         LMMIRESET_N,
  input  logic [NUM_REQ-1:0]           REQ_REQUEST,
  input  logic [NUM_REQ-1:0]           REQ_WRRD_N,
  input  logic [NUM_REQ*OFFSET_W-1:0]  REQ_OFFSET,
  input  logic [NUM_REQ*DATA_W-1:0]    REQ_WDATA,
  output logic [NUM_REQ-1:0]           REQ_READY,
  output logic [DATA_W-1:0]            REQ_RDATA,
  output logic [NUM_REQ-1:0]           REQ_RDATAVALID,
  output logic                         M_REQUEST,
  output logic                         M_WRRD_N,
  output logic [OFFSET_W-1:0]          M_OFFSET,
  output logic [DATA_W-1:0]            M_WDATA,
  input  logic                         M_READY,
  input  logic                         M_RDATAVALID,
  input  logic [DATA_W-1:0]            M_RDATA,
  output logic                         TIMEOUT_ERR,
  output state_t                       o_dbg_state
);

  // Handshake: a request is accepted on any cycle where M_REQUEST and M_READY are both 1;
  // the owner's REQ_READY mirrors M_READY only while granted, read data is a one-cycle strobe.

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_owner;
  logic                  w_next_owner;
  logic                  r_last;
  logic                  w_next_last;
  logic                  w_pick;
  logic                  w_own_req;
  logic                  w_own_wr;
  logic [OFFSET_W-1:0]   w_own_off;
  logic [DATA_W-1:0]     w_own_wd;
  logic                  w_tc;
  logic                  w_cnt_clr;
  logic                  w_cnt_en;

  assign w_pick    = (&REQ_REQUEST) ? ~r_last : REQ_REQUEST[1];
  assign w_own_req = REQ_REQUEST[r_owner];
  assign w_own_wr  = REQ_WRRD_N[r_owner];
  assign w_own_off = r_owner ? REQ_OFFSET[OFFSET_W +: OFFSET_W] : REQ_OFFSET[0 +: OFFSET_W];
  assign w_own_wd  = r_owner ? REQ_WDATA[DATA_W +: DATA_W] : REQ_WDATA[0 +: DATA_W];

  assign w_cnt_en    = (r_state == ST_WAIT_RD);
  assign w_cnt_clr   = ~w_cnt_en;
  assign o_dbg_state = r_state;

  lmmi_timeout_cnt #(
    .TERMINAL (RD_TIMEOUT - 1)
  ) u_timeout_cnt (
    .i_clk   (LMMICLK),
    .i_rst_n (LMMIRESET_N),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_tc    (w_tc)
  );

  always_ff @(posedge LMMICLK or negedge LMMIRESET_N) begin
    if (!LMMIRESET_N) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_owner <= w_next_owner;
      r_last  <= w_next_last;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_owner   = r_owner;
    w_next_last    = r_last;
    REQ_READY      = '0;
    REQ_RDATA      = '0;
    REQ_RDATAVALID = '0;
    M_REQUEST      = 1'b0;
    M_WRRD_N       = 1'b0;
    M_OFFSET       = '0;
    M_WDATA        = '0;
    TIMEOUT_ERR    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|REQ_REQUEST) begin
          w_next_owner = w_pick;
          w_next_state = ST_GRANT;
        end
      end
      ST_GRANT: begin
        M_REQUEST = w_own_req;
        M_WRRD_N  = w_own_wr;
        M_OFFSET  = w_own_off;
        M_WDATA   = w_own_wd;
        REQ_READY = owner_onehot(r_owner) & {NUM_REQ{M_READY}};
        // An abandoned grant leaves priority untouched.
        if (!w_own_req) begin
          w_next_state = ST_IDLE;
        end else if (M_READY) begin
          if (w_own_wr) begin
            w_next_state = ST_IDLE;
            w_next_last  = r_owner;
          end else begin
            w_next_state = ST_WAIT_RD;
          end
        end
      end
      ST_WAIT_RD: begin
        // Real data beats a timeout landing in the same cycle.
        if (M_RDATAVALID) begin
          REQ_RDATA      = M_RDATA;
          REQ_RDATAVALID = owner_onehot(r_owner);
          w_next_state   = ST_IDLE;
          w_next_last    = r_owner;
        end else if (w_tc) begin
          REQ_RDATAVALID = owner_onehot(r_owner);
          TIMEOUT_ERR    = 1'b1;
          w_next_state   = ST_IDLE;
          w_next_last    = r_owner;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule
